// File: rtl/register_file.sv
// Register file with two combinational read ports, one write port and a
// sequential clear sweep. Optional write-through bypass under REGFILE_BYPASS_EN.
module register_file #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [WIDTH-1:0]      read_data1,
  output logic [WIDTH-1:0]      read_data2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  wrenable,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  write_dropped
);

  // state | meaning
  // IDLE  | normal operation, writes accepted
  // CLEAR | sweeping idx_q over 1..DEPTH-1, writing zero; writes dropped
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO  = '0;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    dropped_q, dropped_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];
  logic                    wr_ok;

  assign wr_ok = wrenable && (write_reg != IDX_ZERO);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dropped_d = 1'b0;
    mem_d     = mem_q;
    case (state_q)
      IDLE: begin
        if (wr_ok) mem_d[write_reg] = write_data;
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = IDX_FIRST;
        end
      end
      CLEAR: begin
        mem_d[idx_q] = '0;
        if (wr_ok) dropped_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = IDX_FIRST;
        end else begin
          idx_d = idx_q + IDX_FIRST;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_FIRST;
      end
    endcase
    mem_d[0] = '0;
    busy_d   = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= IDX_FIRST;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    read_data1 = mem_q[read_reg1];
    read_data2 = mem_q[read_reg2];
    if (wr_ok && (state_q == IDLE) && (write_reg == read_reg1)) read_data1 = write_data;
    if (wr_ok && (state_q == IDLE) && (write_reg == read_reg2)) read_data2 = write_data;
  end
`else
  always_comb begin
    read_data1 = mem_q[read_reg1];
    read_data2 = mem_q[read_reg2];
  end
`endif

  assign clear_busy    = busy_q;
  assign write_dropped = dropped_q;

endmodule
